// File: rtl/multi_regs_read.sv
// Drains a ring of single-line input registers into a line RAM, one buffer (bufid) per packet.
// A packet is dropped when no bufid is free (DISC_EN=1) and truncated past 2^LINE_SHIFT lines.
//
// state    | meaning
// IDLE     | waiting for the first line of a packet in reg[rp]
// WAIT_ACK | line presented to the RAM, waiting for i_wdata_ack
// NEXT     | waiting for the next line of the packet being stored
// DISC     | discarding the remaining lines of a packet
module multi_regs_read #(
  parameter int NUM_REGS   = 2,
  parameter int DATA_W     = 134,
  parameter int BUFID_W    = 9,
  parameter int LINE_SHIFT = 7,
  parameter int DISC_EN    = 1,
  localparam int ADDR_W    = BUFID_W + LINE_SHIFT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REGS*DATA_W-1:0]   iv_data,
  input  logic [NUM_REGS-1:0]          iv_write_flag,
  input  logic                         i_bufid_empty,
  input  logic [BUFID_W-1:0]           iv_bufid,
  output logic                         o_bufid_ack,
  output logic [DATA_W-1:0]            ov_wdata,
  output logic                         o_data_wr,
  output logic [ADDR_W-1:0]            ov_data_waddr,
  input  logic                         i_wdata_ack,
  output logic [15:0]                  ov_disc_cnt,
  output logic [15:0]                  ov_ovf_cnt,
  output logic [1:0]                   ov_state
);

  localparam int RP_W  = $clog2(NUM_REGS);
  localparam int CNT_W = LINE_SHIFT + 1;
  localparam logic [RP_W-1:0]  RP_LAST   = RP_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LINES_MAX = CNT_W'(2 ** LINE_SHIFT);
  localparam logic             DISC_ON   = (DISC_EN != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    NEXT     = 2'd2,
    DISC     = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] full_nxt;
  logic [NUM_REGS-1:0] rd_vec;
  logic [RP_W-1:0]     rp;
  logic [RP_W-1:0]     rp_inc;
  logic [CNT_W-1:0]    line_cnt;
  logic [DATA_W-1:0]   cur_line;
  logic                cur_last;
  logic                wr_last;
  logic                rd_en;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs[k] = iv_data[k*DATA_W +: DATA_W];
  end

  assign cur_line = regs[rp];
  // Tag bit [DATA_W-1] is set for tail (10) and single (11): last line of a packet.
  assign cur_last = cur_line[DATA_W-1];
  assign wr_last  = ov_wdata[DATA_W-1];
  assign rp_inc   = (rp == RP_LAST) ? '0 : rp + 1'b1;
  assign ov_state = state;

  always_comb begin
    rd_en = 1'b0;
    case (state)
      IDLE:       rd_en = full[rp] && (!i_bufid_empty || DISC_ON);
      NEXT, DISC: rd_en = full[rp];
      default:    rd_en = 1'b0;
    endcase
  end

  // A load and a read landing on the same register in one cycle cancel out.
  assign rd_vec   = rd_en ? (NUM_REGS'(1) << rp) : '0;
  assign full_nxt = (full & ~(rd_vec & ~iv_write_flag)) | (iv_write_flag & ~rd_vec);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      full          <= '0;
      rp            <= '0;
      line_cnt      <= '0;
      o_bufid_ack   <= 1'b0;
      ov_wdata      <= '0;
      o_data_wr     <= 1'b0;
      ov_data_waddr <= '0;
      ov_disc_cnt   <= '0;
      ov_ovf_cnt    <= '0;
    end else begin
      full        <= full_nxt;
      o_bufid_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rp]) begin
            if (!i_bufid_empty) begin
              ov_wdata      <= cur_line;
              o_data_wr     <= 1'b1;
              ov_data_waddr <= {iv_bufid, {LINE_SHIFT{1'b0}}};
              o_bufid_ack   <= 1'b1;
              line_cnt      <= CNT_W'(1);
              state         <= WAIT_ACK;
            end else if (DISC_ON) begin
              if (ov_disc_cnt != 16'hFFFF) ov_disc_cnt <= ov_disc_cnt + 16'd1;
              rp    <= rp_inc;
              state <= cur_last ? IDLE : DISC;
            end
          end
        end
        WAIT_ACK: begin
          if (i_wdata_ack) begin
            o_data_wr <= 1'b0;
            rp        <= rp_inc;
            state     <= wr_last ? IDLE : NEXT;
          end
        end
        NEXT: begin
          if (full[rp]) begin
            if (line_cnt < LINES_MAX) begin
              ov_wdata      <= cur_line;
              o_data_wr     <= 1'b1;
              ov_data_waddr <= ov_data_waddr + 1'b1;
              line_cnt      <= line_cnt + 1'b1;
              state         <= WAIT_ACK;
            end else begin
              if (ov_ovf_cnt != 16'hFFFF) ov_ovf_cnt <= ov_ovf_cnt + 16'd1;
              rp    <= rp_inc;
              state <= cur_last ? IDLE : DISC;
            end
          end
        end
        DISC: begin
          if (full[rp]) begin
            rp    <= rp_inc;
            state <= cur_last ? IDLE : DISC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multi_regs_read.md
MULTI_REGS_READ -- requirements
Module: multi_regs_read

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 2, number of single-line input registers read round-robin (2..8).
REQ-002 SHALL provide parameter DATA_W, default 134, line width; bits [DATA_W-1:DATA_W-2] are the line tag: 01 head, 00 middle, 10 tail, 11 single-line packet.
REQ-003 SHALL provide parameter BUFID_W, default 9, buffer-id width.
REQ-004 SHALL provide parameter LINE_SHIFT, default 7, log2 of lines per buffer; ADDR_W = BUFID_W + LINE_SHIFT.
REQ-005 SHALL provide parameter DISC_EN, default 1; 1 = drop a packet when no bufid is free, 0 = stall until a bufid is free.
REQ-006 i_clk  input  1  sole clock.
REQ-007 i_rst  input  1  reset, asynchronous, active-high.
REQ-008 iv_data  input  NUM_REGS*DATA_W  register contents; register k occupies slice k.
REQ-009 iv_write_flag  input  NUM_REGS  one-cycle pulse per register, meaning that register was loaded.
REQ-010 i_bufid_empty  input  1  high = no free bufid.
REQ-011 iv_bufid  input  BUFID_W  current free bufid, valid when i_bufid_empty is low.
REQ-012 o_bufid_ack  output  1  one-cycle pulse consuming iv_bufid.
REQ-013 ov_wdata  output  DATA_W  line to RAM.
REQ-014 o_data_wr  output  1  write request, held until acked.
REQ-015 ov_data_waddr  output  ADDR_W  RAM line address.
REQ-016 i_wdata_ack  input  1  RAM accepted the current write.
REQ-017 ov_disc_cnt  output  16  count of packets dropped for lack of bufid, saturating at 0xFFFF.
REQ-018 ov_ovf_cnt  output  16  count of packets truncated for exceeding 2^LINE_SHIFT lines, saturating at 0xFFFF.
REQ-019 ov_state  output  2  FSM state, for debug.

Function
REQ-020 SHALL keep one full flag per register: write-only sets it, read-only clears it, write and read in the same cycle leave it unchanged, neither leaves it unchanged.
REQ-021 SHALL hold a read pointer rp (0..NUM_REGS-1) that advances by 1 modulo NUM_REGS after every line is consumed, whether written or dropped.
REQ-022 SHALL implement states IDLE=0, WAIT_ACK=1, NEXT=2, DISC=3.
REQ-023 IDLE, full[rp] and !i_bufid_empty: SHALL drive ov_wdata=reg[rp], o_data_wr=1, ov_data_waddr={iv_bufid,LINE_SHIFT'b0}, pulse o_bufid_ack and the read of rp for one cycle, reset the line counter to 1, and go to WAIT_ACK.
REQ-024 IDLE, full[rp], i_bufid_empty=1, DISC_EN=1: SHALL consume reg[rp] without writing, increment ov_disc_cnt once per packet, advance rp, then go to IDLE if the line is tail/single, else to DISC.
REQ-025 IDLE, full[rp], i_bufid_empty=1, DISC_EN=0: SHALL stay in IDLE with no side effects.
REQ-026 WAIT_ACK: SHALL hold o_data_wr, ov_wdata and ov_data_waddr stable until i_wdata_ack=1; on ack, SHALL clear o_data_wr and advance rp; a tail/single line SHALL go to IDLE, any other line to NEXT.
REQ-027 NEXT, full[rp]: if line counter < 2^LINE_SHIFT, SHALL write reg[rp] at ov_data_waddr+1, increment the counter, read rp, and go to WAIT_ACK; otherwise SHALL increment ov_ovf_cnt and treat the packet as dropped (REQ-028 path).
REQ-028 DISC: SHALL consume one line per cycle while full[rp] is set, advancing rp each time, and go to IDLE on a tail/single line; no RAM writes and no bufid ack.
REQ-029 A tag mismatch (head seen in NEXT or DISC) SHALL be treated as a middle line; no resync.
REQ-030 Empty register in NEXT or DISC SHALL stall in place with o_data_wr=0.
REQ-031 Latency: register full to o_data_wr high SHALL be 1 cycle; ack to next o_data_wr SHALL be at least 2 cycles.

Reset
REQ-032 i_rst high SHALL asynchronously force: all outputs 0, full flags 0, rp=0, counters 0, state IDLE; a packet in flight SHALL be abandoned without completing.

Verification
REQ-033 NUM_REGS=2, 3-line packet (01,00,10), bufid 5, 1-cycle ack -> writes at addresses 0x280, 0x281, 0x282, one bufid ack, rp ends at 1.
REQ-034 NUM_REGS=4, two back-to-back single-line packets, bufids 3 then 4 -> writes at 0x180 and 0x200, rp ends at 2.
REQ-035 DISC_EN=1, i_bufid_empty=1, 4-line packet -> no o_data_wr, no bufid ack, ov_disc_cnt=1, FSM in IDLE after the tail.
REQ-036 LINE_SHIFT=2, 6-line packet -> 4 writes, ov_ovf_cnt=1, last 2 lines dropped, next packet written normally.
REQ-037 i_wdata_ack held low 10 cycles -> o_data_wr and the address stay stable; write flag and read pulse in the same cycle -> full flag unchanged.
REQ-038 i_rst asserted mid-packet in WAIT_ACK -> all outputs 0 immediately, state IDLE; the next head packet is processed normally.
